// File: rtl/iiq_wakeup_select_pkg.sv
// Shared types and defaults for the integer issue-queue scheduler.
// Entry layout is common to the queue storage and its wakeup logic.
package iiq_wakeup_select_pkg;

    localparam int unsigned IIQ_DEPTH = 8;
    localparam int unsigned TAG_WIDTH = 6;
    localparam int unsigned N_WAKEUP  = 2;

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] src1_tag;
        logic                 src1_rdy;
        logic [TAG_WIDTH-1:0] src2_tag;
        logic                 src2_rdy;
        logic                 dst_valid;
        logic [TAG_WIDTH-1:0] dst_tag;
    } iiq_sched_entry_t;

endpackage

// File: rtl/iiq_oldest_ready_picker.sv
// Priority encoder: lowest set ready bit is the oldest ready entry.
module iiq_oldest_ready_picker #(
    parameter  int unsigned N  = 8,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic [N-1:0]  ready_i,
    output logic          valid_o,
    output logic [SW-1:0] slot_o
);

    always_comb begin
        valid_o = |ready_i;
        slot_o  = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (ready_i[i]) slot_o = SW'(i);
        end
    end

endmodule

// File: rtl/iiq_wakeup_select.sv
// Collapsing integer issue queue with tag wakeup and oldest-ready select.
// Issued destinations wake dependents in the same edge (back-to-back issue).
module iiq_wakeup_select #(
    parameter  int unsigned IIQ_DEPTH = iiq_wakeup_select_pkg::IIQ_DEPTH,
    parameter  int unsigned TAG_WIDTH = iiq_wakeup_select_pkg::TAG_WIDTH,
    parameter  int unsigned N_WAKEUP  = iiq_wakeup_select_pkg::N_WAKEUP,
    localparam int unsigned SW        = $clog2(IIQ_DEPTH),
    localparam int unsigned OW        = $clog2(IIQ_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_aL,
    input  logic                          flush,
    input  logic                          alloc_valid,
    output logic                          alloc_ready,
    input  logic [TAG_WIDTH-1:0]          alloc_src1_tag,
    input  logic                          alloc_src1_rdy,
    input  logic [TAG_WIDTH-1:0]          alloc_src2_tag,
    input  logic                          alloc_src2_rdy,
    input  logic                          alloc_dst_valid,
    input  logic [TAG_WIDTH-1:0]          alloc_dst_tag,
    input  logic [N_WAKEUP-1:0]           wakeup_valid,
    input  logic [N_WAKEUP*TAG_WIDTH-1:0] wakeup_tag,
    output logic                          issue_valid,
    input  logic                          issue_ready,
    output logic [SW-1:0]                 issue_slot,
    output logic                          issue_dst_valid,
    output logic [TAG_WIDTH-1:0]          issue_dst_tag,
    output logic [OW-1:0]                 occupancy
);

    import iiq_wakeup_select_pkg::iiq_sched_entry_t;

    localparam int unsigned NB = N_WAKEUP + 1;

    iiq_sched_entry_t     entries_q [IIQ_DEPTH];
    iiq_sched_entry_t     entries_d [IIQ_DEPTH];
    iiq_sched_entry_t     woken     [IIQ_DEPTH];
    iiq_sched_entry_t     alloc_e;
    logic [OW-1:0]        occ_q, occ_d;
    logic [OW-1:0]        wr_idx;
    logic [IIQ_DEPTH-1:0] rdy_vec;
    logic [SW-1:0]        sel;
    logic                 sel_valid;
    logic                 issue_fire;
    logic                 alloc_fire;
    logic                 bc_valid  [NB];
    logic [TAG_WIDTH-1:0] bc_tag    [NB];
    logic [IIQ_DEPTH:0]   hit1, hit2;

    always_comb begin
        for (int k = 0; k < int'(IIQ_DEPTH); k++) begin
            rdy_vec[k] = entries_q[k].valid & entries_q[k].src1_rdy
                       & entries_q[k].src2_rdy;
        end
    end

    iiq_oldest_ready_picker #(
        .N(IIQ_DEPTH)
    ) u_picker (
        .ready_i(rdy_vec),
        .valid_o(sel_valid),
        .slot_o (sel)
    );

    always_comb begin
        issue_valid     = sel_valid;
        issue_slot      = '0;
        issue_dst_valid = 1'b0;
        issue_dst_tag   = '0;
        if (sel_valid) begin
            issue_slot      = sel;
            issue_dst_valid = entries_q[sel].dst_valid;
            issue_dst_tag   = entries_q[sel].dst_tag;
        end
    end

    assign occupancy   = occ_q;
    assign alloc_ready = (occ_q < OW'(IIQ_DEPTH));
    assign issue_fire  = issue_valid & issue_ready;
    assign alloc_fire  = alloc_valid & alloc_ready;

    // Last broadcast lane is the self-wakeup from the issuing entry.
    always_comb begin
        for (int b = 0; b < int'(N_WAKEUP); b++) begin
            bc_valid[b] = wakeup_valid[b];
            bc_tag[b]   = wakeup_tag[b*TAG_WIDTH +: TAG_WIDTH];
        end
        bc_valid[N_WAKEUP] = issue_fire & issue_dst_valid;
        bc_tag[N_WAKEUP]   = issue_dst_tag;
    end

    for (genvar k = 0; k <= IIQ_DEPTH; k++) begin : g_cam
        logic [TAG_WIDTH-1:0] t1, t2;
        logic                 h1, h2;
        if (k < IIQ_DEPTH) begin : g_slot
            assign t1 = entries_q[k].src1_tag;
            assign t2 = entries_q[k].src2_tag;
        end else begin : g_alloc
            assign t1 = alloc_src1_tag;
            assign t2 = alloc_src2_tag;
        end
        always_comb begin
            h1 = 1'b0;
            h2 = 1'b0;
            for (int b = 0; b < int'(NB); b++) begin
                h1 = h1 | (bc_valid[b] && (bc_tag[b] == t1));
                h2 = h2 | (bc_valid[b] && (bc_tag[b] == t2));
            end
        end
        assign hit1[k] = h1;
        assign hit2[k] = h2;
    end

    always_comb begin
        for (int k = 0; k < int'(IIQ_DEPTH); k++) begin
            woken[k]          = entries_q[k];
            woken[k].src1_rdy = entries_q[k].src1_rdy | hit1[k];
            woken[k].src2_rdy = entries_q[k].src2_rdy | hit2[k];
        end
        alloc_e.valid     = 1'b1;
        alloc_e.src1_tag  = alloc_src1_tag;
        alloc_e.src1_rdy  = alloc_src1_rdy | hit1[IIQ_DEPTH];
        alloc_e.src2_tag  = alloc_src2_tag;
        alloc_e.src2_rdy  = alloc_src2_rdy | hit2[IIQ_DEPTH];
        alloc_e.dst_valid = alloc_dst_valid;
        alloc_e.dst_tag   = alloc_dst_tag;
    end

    // Compact above the issued slot, then write the new tail.
    always_comb begin
        wr_idx = occ_q - OW'(issue_fire);
        for (int k = 0; k < int'(IIQ_DEPTH); k++) begin
            entries_d[k] = woken[k];
            if (issue_fire && k >= int'(sel)) begin
                if (k < int'(IIQ_DEPTH) - 1) entries_d[k] = woken[SW'(k + 1)];
                else                         entries_d[k] = '0;
            end
            if (alloc_fire && OW'(k) == wr_idx) entries_d[k] = alloc_e;
        end
        occ_d = occ_q + OW'(alloc_fire) - OW'(issue_fire);
        if (flush) begin
            for (int k = 0; k < int'(IIQ_DEPTH); k++) entries_d[k] = '0;
            occ_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            for (int k = 0; k < int'(IIQ_DEPTH); k++) entries_q[k] <= '0;
            occ_q <= '0;
        end else begin
            entries_q <= entries_d;
            occ_q     <= occ_d;
        end
    end

endmodule

// File: tb/tb_iiq_wakeup_select.sv
// Directed bench for the issue-queue scheduler with hand-computed expectations.
module tb_iiq_wakeup_select;

    logic        clk = 1'b0;
    logic        rst_aL;
    logic        flush;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [5:0]  alloc_src1_tag;
    logic        alloc_src1_rdy;
    logic [5:0]  alloc_src2_tag;
    logic        alloc_src2_rdy;
    logic        alloc_dst_valid;
    logic [5:0]  alloc_dst_tag;
    logic [1:0]  wakeup_valid;
    logic [11:0] wakeup_tag;
    logic        issue_valid;
    logic        issue_ready;
    logic [2:0]  issue_slot;
    logic        issue_dst_valid;
    logic [5:0]  issue_dst_tag;
    logic [3:0]  occupancy;

    int passed = 0;
    int total  = 0;

    iiq_wakeup_select dut (
        .clk            (clk),
        .rst_aL         (rst_aL),
        .flush          (flush),
        .alloc_valid    (alloc_valid),
        .alloc_ready    (alloc_ready),
        .alloc_src1_tag (alloc_src1_tag),
        .alloc_src1_rdy (alloc_src1_rdy),
        .alloc_src2_tag (alloc_src2_tag),
        .alloc_src2_rdy (alloc_src2_rdy),
        .alloc_dst_valid(alloc_dst_valid),
        .alloc_dst_tag  (alloc_dst_tag),
        .wakeup_valid   (wakeup_valid),
        .wakeup_tag     (wakeup_tag),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_slot     (issue_slot),
        .issue_dst_valid(issue_dst_valid),
        .issue_dst_tag  (issue_dst_tag),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [5:0] t1, input logic r1,
                         input logic [5:0] t2, input logic r2,
                         input logic dv, input logic [5:0] dt);
        alloc_valid     = 1'b1;
        alloc_src1_tag  = t1;
        alloc_src1_rdy  = r1;
        alloc_src2_tag  = t2;
        alloc_src2_rdy  = r2;
        alloc_dst_valid = dv;
        alloc_dst_tag   = dt;
    endtask

    task automatic no_alloc();
        alloc_valid     = 1'b0;
        alloc_src1_tag  = '0;
        alloc_src1_rdy  = 1'b0;
        alloc_src2_tag  = '0;
        alloc_src2_rdy  = 1'b0;
        alloc_dst_valid = 1'b0;
        alloc_dst_tag   = '0;
    endtask

    initial begin
        rst_aL       = 1'b0;
        flush        = 1'b0;
        issue_ready  = 1'b0;
        wakeup_valid = '0;
        wakeup_tag   = '0;
        no_alloc();

        // reset state
        #12;
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_issue_slot", issue_slot, 0);
        chk("rst_dst_valid", issue_dst_valid, 0);
        chk("rst_dst_tag", issue_dst_tag, 0);
        chk("rst_occ", occupancy, 0);
        rst_aL = 1'b1;
        #1;
        chk("rst_alloc_ready", alloc_ready, 1);

        // three ready entries, in-order issue from slot 0
        step();
        alloc(6'd0, 1'b1, 6'd0, 1'b1, 1'b1, 6'd1);
        chk("a_pre_valid", issue_valid, 0);
        step();
        chk("a1_occ", occupancy, 1);
        chk("a1_valid", issue_valid, 1);
        chk("a1_tag", issue_dst_tag, 1);
        alloc(6'd0, 1'b1, 6'd0, 1'b1, 1'b1, 6'd2);
        step();
        chk("a2_occ", occupancy, 2);
        chk("a2_tag", issue_dst_tag, 1);
        alloc(6'd0, 1'b1, 6'd0, 1'b1, 1'b1, 6'd3);
        issue_ready = 1'b1;
        step();
        chk("a3_occ", occupancy, 2);
        chk("a3_slot", issue_slot, 0);
        chk("a3_tag", issue_dst_tag, 2);
        no_alloc();
        step();
        chk("a4_occ", occupancy, 1);
        chk("a4_slot", issue_slot, 0);
        chk("a4_tag", issue_dst_tag, 3);
        step();
        chk("a5_occ", occupancy, 0);
        chk("a5_valid", issue_valid, 0);
        chk("a5_tag", issue_dst_tag, 0);
        issue_ready = 1'b0;

        // back-to-back dependent issue via self-wakeup
        alloc(6'd0, 1'b1, 6'd0, 1'b1, 1'b1, 6'd5);
        step();
        alloc(6'd5, 1'b0, 6'd0, 1'b1, 1'b1, 6'd6);
        step();
        no_alloc();
        chk("b_occ", occupancy, 2);
        chk("b_head_tag", issue_dst_tag, 5);
        issue_ready = 1'b1;
        step();
        chk("b_dep_valid", issue_valid, 1);
        chk("b_dep_tag", issue_dst_tag, 6);
        chk("b_dep_occ", occupancy, 1);
        step();
        chk("b_empty", issue_valid, 0);
        chk("b_empty_occ", occupancy, 0);
        issue_ready = 1'b0;

        // fill with blocked entries; entries 3 and 5 wait on tag 33
        for (int i = 0; i < 8; i++) begin
            if (i == 3 || i == 5) alloc(6'd33, 1'b0, 6'd0, 1'b1, 1'b1, 6'(10 + i));
            else alloc(6'(40 + i), 1'b0, 6'd0, 1'b1, 1'b1, 6'(10 + i));
            step();
        end
        no_alloc();
        chk("c_occ_full", occupancy, 8);
        chk("c_alloc_ready", alloc_ready, 0);
        chk("c_blocked", issue_valid, 0);
        wakeup_valid = 2'b00;
        wakeup_tag   = {6'd33, 6'd40};
        step();
        chk("c_invalid_port", issue_valid, 0);
        wakeup_valid = 2'b10;
        step();
        wakeup_valid = 2'b00;
        wakeup_tag   = '0;
        chk("c_wake_valid", issue_valid, 1);
        chk("c_wake_slot", issue_slot, 3);
        chk("c_wake_tag", issue_dst_tag, 13);

        // full queue: alloc blocked during a firing cycle
        alloc(6'd0, 1'b1, 6'd0, 1'b1, 1'b1, 6'd50);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        chk("d_occ7", occupancy, 7);
        chk("d_alloc_ready", alloc_ready, 1);
        chk("d_slot", issue_slot, 4);
        chk("d_tag", issue_dst_tag, 15);
        step();
        no_alloc();
        chk("d_occ8", occupancy, 8);
        chk("d_full", alloc_ready, 0);
        chk("d_slot_keep", issue_slot, 4);

        // flush with simultaneous issue
        flush       = 1'b1;
        issue_ready = 1'b1;
        #1;
        chk("e_issue_driven", issue_valid, 1);
        step();
        flush       = 1'b0;
        issue_ready = 1'b0;
        chk("e_occ", occupancy, 0);
        chk("e_valid", issue_valid, 0);
        chk("e_alloc_ready", alloc_ready, 1);
        alloc(6'd0, 1'b1, 6'd0, 1'b1, 1'b1, 6'd60);
        step();
        no_alloc();
        chk("e_new_slot", issue_slot, 0);
        chk("e_new_tag", issue_dst_tag, 60);
        chk("e_new_occ", occupancy, 1);
        issue_ready = 1'b1;
        step();
        chk("e_drained", occupancy, 0);

        // allocation-cycle bypass, full-width tag compare
        alloc(6'd0, 1'b1, 6'd9, 1'b0, 1'b1, 6'd61);
        wakeup_valid = 2'b01;
        wakeup_tag   = {6'd0, 6'd9};
        step();
        no_alloc();
        wakeup_valid = 2'b00;
        wakeup_tag   = '0;
        chk("f_bypass_valid", issue_valid, 1);
        chk("f_bypass_tag", issue_dst_tag, 61);
        step();
        chk("f_bypass_occ", occupancy, 0);
        alloc(6'd0, 1'b1, 6'd41, 1'b0, 1'b1, 6'd62);
        wakeup_valid = 2'b01;
        wakeup_tag   = {6'd0, 6'd9};
        step();
        no_alloc();
        wakeup_valid = 2'b00;
        chk("f_msb_nomatch", issue_valid, 0);
        chk("f_msb_occ", occupancy, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
